// File: rtl/vid_timing_pkg.sv
// rtl/vid_timing_pkg.sv - shared types, widths and helpers for the video timing monitor
package vid_timing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } vtm_state_t;

    localparam int ERR_W = 16;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vid_period_counter.sv
// rtl/vid_period_counter.sv - edge-restarted saturating counter with a latch of the closed period
module vid_period_counter #(
    parameter int W            = 8,
    parameter bit INC_ON_CLOSE = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         restart,
    input  logic         inc,
    output logic [W-1:0] latched
);

    logic [W-1:0] count;
    logic [W-1:0] count_inc;

    assign count_inc = (count == {W{1'b1}}) ? count : count + 1'b1;

    // INC_ON_CLOSE: an increment coinciding with restart belongs to the period
    // being closed; otherwise it is the first event of the new period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count   <= '0;
            latched <= '0;
        end else if (restart) begin
            if (INC_ON_CLOSE) begin
                latched <= inc ? count_inc : count;
                count   <= '0;
            end else begin
                latched <= count;
                count   <= {{(W-1){1'b0}}, inc};
            end
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/vid_timing_monitor.sv
// rtl/vid_timing_monitor.sv - raster measurement, per-frame compare and lock FSM for the pixel-clock video path
module vid_timing_monitor
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE    = -1,
    parameter int H_FRAME     = -1,
    parameter int V_ACTIVE    = -1,
    parameter int V_FRAME     = -1,
    parameter int SYNC_POL    = 1,
    parameter int LOCK_FRAMES = 2,
    localparam int HW         = (H_FRAME > 0) ? $clog2(H_FRAME + 1) : 1,
    localparam int VW         = (V_FRAME > 0) ? $clog2(V_FRAME + 1) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_vde,
    input  logic             clr_err,
    output logic             out_locked,
    output logic             out_frame_ok,
    output logic             out_frame_err,
    output logic [ERR_W-1:0] out_err_cnt,
    output logic [HW-1:0]    out_meas_h_total,
    output logic [HW-1:0]    out_meas_h_active,
    output logic [VW-1:0]    out_meas_v_total,
    output logic [VW-1:0]    out_meas_v_active,
    output logic [1:0]       out_state
);

    localparam logic POL         = ((SYNC_POL & 1) != 0);
    localparam int   TIMEOUT     = (H_FRAME > 0 && V_FRAME > 0) ? 2 * H_FRAME * V_FRAME : 2;
    localparam int   TW          = $clog2(TIMEOUT + 1);
    localparam int   GW          = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

    localparam logic [HW-1:0] H_FRAME_C  = HW'(H_FRAME);
    localparam logic [HW-1:0] H_ACTIVE_C = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_FRAME_C  = VW'(V_FRAME);
    localparam logic [VW-1:0] V_ACTIVE_C = VW'(V_ACTIVE);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LOCK_LAST  = GW'(LOCK_FRAMES - 1);

    logic hs_r, vs_r, vde_r, hs_d, vs_d;
    logic h_edge, v_edge, v_edge_d;
    logic line_vde;
    logic frame_good;
    logic timeout_hit;
    logic err_event;

    vtm_state_t  state;
    logic [GW-1:0] good_cnt;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            vde_r <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            hs_r  <= in_hsync ~^ POL;
            vs_r  <= in_vsync ~^ POL;
            vde_r <= in_vde;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
        end
    end

    assign h_edge = hs_r & ~hs_d;
    assign v_edge = vs_r & ~vs_d;

    // VDE seen on the edge cycle itself belongs to the line that edge opens.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_vde <= 1'b0;
        end else if (h_edge) begin
            line_vde <= vde_r;
        end else if (vde_r) begin
            line_vde <= 1'b1;
        end
    end

    vid_period_counter #(.W(HW), .INC_ON_CLOSE(1'b0)) u_h_total (
        .clk     (clk),
        .rstn    (rstn),
        .restart (h_edge),
        .inc     (1'b1),
        .latched (out_meas_h_total)
    );

    vid_period_counter #(.W(HW), .INC_ON_CLOSE(1'b0)) u_h_active (
        .clk     (clk),
        .rstn    (rstn),
        .restart (h_edge),
        .inc     (vde_r),
        .latched (out_meas_h_active)
    );

    vid_period_counter #(.W(VW), .INC_ON_CLOSE(1'b1)) u_v_total (
        .clk     (clk),
        .rstn    (rstn),
        .restart (v_edge),
        .inc     (h_edge),
        .latched (out_meas_v_total)
    );

    vid_period_counter #(.W(VW), .INC_ON_CLOSE(1'b1)) u_v_active (
        .clk     (clk),
        .rstn    (rstn),
        .restart (v_edge),
        .inc     (h_edge & line_vde),
        .latched (out_meas_v_active)
    );

    assign frame_good  = (out_meas_h_total  == H_FRAME_C)  &&
                         (out_meas_h_active == H_ACTIVE_C) &&
                         (out_meas_v_total  == V_FRAME_C)  &&
                         (out_meas_v_active == V_ACTIVE_C);
    assign timeout_hit = (state != IDLE) && (tmo_cnt == TMO_LAST) && !v_edge;
    assign err_event   = timeout_hit || (v_edge_d && (state != IDLE) && !frame_good);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_edge_d <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            v_edge_d <= v_edge;
            if (v_edge || state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != {TW{1'b1}}) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Measurements settle one cycle after the v edge; decisions land one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            good_cnt      <= '0;
            out_locked    <= 1'b0;
            out_frame_ok  <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            out_frame_ok  <= 1'b0;
            out_frame_err <= 1'b0;
            if (timeout_hit) begin
                state         <= IDLE;
                good_cnt      <= '0;
                out_locked    <= 1'b0;
                out_frame_err <= 1'b1;
            end else if (v_edge_d) begin
                case (state)
                    IDLE: begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                    ACQ: begin
                        if (frame_good) begin
                            out_frame_ok <= 1'b1;
                            good_cnt     <= good_cnt + 1'b1;
                            if (good_cnt == LOCK_LAST) begin
                                state      <= LOCKED;
                                out_locked <= 1'b1;
                            end
                        end else begin
                            out_frame_err <= 1'b1;
                            good_cnt      <= '0;
                        end
                    end
                    LOCKED: begin
                        if (frame_good) begin
                            out_frame_ok <= 1'b1;
                        end else begin
                            out_frame_err <= 1'b1;
                            state         <= ACQ;
                            good_cnt      <= '0;
                            out_locked    <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        good_cnt   <= '0;
                        out_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_err_cnt <= '0;
        end else if (clr_err) begin
            out_err_cnt <= '0;
        end else if (err_event) begin
            out_err_cnt <= sat_inc(out_err_cnt);
        end
    end

    assign out_state = state;

endmodule

// File: tb/tb_vid_timing_monitor.sv
// tb/tb_vid_timing_monitor.sv - frame-table and corner-sequence bench for vid_timing_monitor
module tb_vid_timing_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, hs, vs, vde, clr_err;
    logic hs_n, vs_n;
    assign hs_n = ~hs;
    assign vs_n = ~vs;

    logic        a_locked, a_ok, a_err, b_locked, b_ok, b_err;
    logic [15:0] a_err_cnt, b_err_cnt;
    logic [4:0]  a_h_tot, a_h_act, b_h_tot, b_h_act;
    logic [3:0]  a_v_tot, a_v_act, b_v_tot, b_v_act;
    logic [1:0]  a_state, b_state;

    vid_timing_monitor #(
        .H_ACTIVE(16), .H_FRAME(24), .V_ACTIVE(8), .V_FRAME(12), .SYNC_POL(1), .LOCK_FRAMES(2)
    ) dut_a (
        .clk(clk), .rstn(rstn), .in_hsync(hs), .in_vsync(vs), .in_vde(vde), .clr_err(clr_err),
        .out_locked(a_locked), .out_frame_ok(a_ok), .out_frame_err(a_err), .out_err_cnt(a_err_cnt),
        .out_meas_h_total(a_h_tot), .out_meas_h_active(a_h_act),
        .out_meas_v_total(a_v_tot), .out_meas_v_active(a_v_act), .out_state(a_state)
    );

    vid_timing_monitor #(
        .H_ACTIVE(16), .H_FRAME(24), .V_ACTIVE(8), .V_FRAME(12), .SYNC_POL(0), .LOCK_FRAMES(2)
    ) dut_b (
        .clk(clk), .rstn(rstn), .in_hsync(hs_n), .in_vsync(vs_n), .in_vde(vde), .clr_err(clr_err),
        .out_locked(b_locked), .out_frame_ok(b_ok), .out_frame_err(b_err), .out_err_cnt(b_err_cnt),
        .out_meas_h_total(b_h_tot), .out_meas_h_active(b_h_act),
        .out_meas_v_total(b_v_tot), .out_meas_v_active(b_v_act), .out_state(b_state)
    );

    int cyc = 0;
    int n_ok = 0, n_err = 0, last_ok = -1, last_err = -1, both_seen = 0, pol_mis = 0;
    int clr_at = -1;
    int errors = 0, checks = 0;
    bit lk_at [65536];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        lk_at[cyc[15:0]] <= a_locked;
        if (a_ok) begin
            n_ok    <= n_ok + 1;
            last_ok <= cyc;
        end
        if (a_err) begin
            n_err    <= n_err + 1;
            last_err <= cyc;
        end
        if (a_ok && a_err) both_seen <= both_seen + 1;
        if ({a_locked, a_ok, a_err, a_err_cnt, a_h_tot, a_h_act, a_v_tot, a_v_act, a_state} !==
            {b_locked, b_ok, b_err, b_err_cnt, b_h_tot, b_h_act, b_v_tot, b_v_act, b_state})
            pol_mis <= pol_mis + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit h, input bit v, input bit d);
        hs      = h;
        vs      = v;
        vde     = d;
        clr_err = (cyc == clr_at);
        @(posedge clk);
        #1;
    endtask

    // Sync pulses in pixels 0..1 and lines 0..1; active lines 4..11, pixels 4..19.
    task automatic send_frame(input bit stretch, output int start);
        start = cyc;
        for (int l = 0; l < 12; l++) begin
            for (int p = 0; p < ((stretch && l == 11) ? 25 : 24); p++) begin
                step(p < 2, l < 2, (l >= 4) && (p >= 4) && (p < 20));
            end
        end
    endtask

    task automatic dead_lines(input int n);
        for (int l = 0; l < n; l++) begin
            for (int p = 0; p < 24; p++) step(p < 2, 1'b0, 1'b0);
        end
    endtask

    task automatic timeout_seq(input int vstart);
        int e0;
        e0 = n_err;
        dead_lines(30);
        chk("tmo_pulse_count", n_err - e0, 1);
        chk("tmo_pulse_window", int'(last_err >= vstart + 576 && last_err <= vstart + 582), 1);
        chk("tmo_state", int'(a_state), 0);
        chk("tmo_locked", int'(a_locked), 0);
        chk("tmo_err_cnt", int'(a_err_cnt), 2);
    endtask

    task automatic reset_seq();
        dead_lines(4);
        chk("pre_reset_locked", int'(a_locked), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_locked", int'(a_locked), 0);
        chk("rst_pulses", int'(a_ok) + int'(a_err), 0);
        chk("rst_err_cnt", int'(a_err_cnt), 0);
        chk("rst_state", int'(a_state), 0);
        chk("rst_meas", int'(a_h_tot) + int'(a_h_act) + int'(a_v_tot) + int'(a_v_act), 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        int pre;       // 0 none, 1 timeout sequence, 2 reset sequence
        bit stretch;   // last line 25 clocks
        bit clr;       // clr_err on the error-increment cycle
        int pulse;     // 0 none, 1 ok, 2 err for this frame's leading v edge
        bit locked;
        int state;
        int err;
        bit meas;      // nominal 24/16/12/8 at end of frame
        bit vsat;      // v totals saturated after the long gap
    } row_t;

    row_t rows [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int st, last_start, ok0, err0, lk_prev;

        rows[0]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        rows[1]  = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
        rows[2]  = '{0, 0, 0, 1, 1, 2, 0, 1, 0};
        rows[3]  = '{0, 0, 0, 1, 1, 2, 0, 1, 0};
        rows[4]  = '{0, 1, 0, 1, 1, 2, 0, 1, 0};
        rows[5]  = '{0, 0, 0, 2, 0, 1, 1, 1, 0};
        rows[6]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0};
        rows[7]  = '{0, 0, 0, 1, 1, 2, 1, 1, 0};
        rows[8]  = '{1, 0, 0, 0, 0, 1, 2, 0, 1};
        rows[9]  = '{0, 1, 0, 1, 0, 1, 2, 1, 0};
        rows[10] = '{0, 0, 1, 2, 0, 1, 0, 1, 0};
        rows[11] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
        rows[12] = '{0, 0, 0, 1, 1, 2, 0, 1, 0};
        rows[13] = '{2, 0, 0, 0, 0, 1, 0, 0, 0};
        rows[14] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
        rows[15] = '{0, 0, 0, 1, 1, 2, 0, 1, 0};

        rstn = 1'b0; hs = 1'b0; vs = 1'b0; vde = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", int'(a_locked), 0);
        chk("reset_state", int'(a_state), 0);
        chk("reset_err_cnt", int'(a_err_cnt), 0);
        chk("reset_meas", int'(a_h_tot) + int'(a_h_act) + int'(a_v_tot) + int'(a_v_act), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        last_start = 0;
        for (int i = 0; i < 16; i++) begin
            if (rows[i].pre == 1) timeout_seq(last_start);
            if (rows[i].pre == 2) reset_seq();
            ok0     = n_ok;
            err0    = n_err;
            lk_prev = int'(a_locked);
            if (rows[i].clr) clr_at = cyc + 2;
            send_frame(rows[i].stretch, st);
            clr_at = -1;
            chk($sformatf("row%0d ok_pulses", i), n_ok - ok0, int'(rows[i].pulse == 1));
            chk($sformatf("row%0d err_pulses", i), n_err - err0, int'(rows[i].pulse == 2));
            if (rows[i].pulse == 1) chk($sformatf("row%0d ok_cycle", i), last_ok, st + 3);
            if (rows[i].pulse == 2) chk($sformatf("row%0d err_cycle", i), last_err, st + 3);
            chk($sformatf("row%0d locked_before_pulse", i), int'(lk_at[st + 2]), lk_prev);
            chk($sformatf("row%0d locked_at_pulse", i), int'(lk_at[st + 3]), int'(rows[i].locked));
            chk($sformatf("row%0d locked", i), int'(a_locked), int'(rows[i].locked));
            chk($sformatf("row%0d state", i), int'(a_state), rows[i].state);
            chk($sformatf("row%0d err_cnt", i), int'(a_err_cnt), rows[i].err);
            if (rows[i].meas) begin
                chk($sformatf("row%0d h_total", i), int'(a_h_tot), 24);
                chk($sformatf("row%0d h_active", i), int'(a_h_act), 16);
                chk($sformatf("row%0d v_total", i), int'(a_v_tot), 12);
                chk($sformatf("row%0d v_active", i), int'(a_v_act), 8);
            end
            if (rows[i].vsat) begin
                chk($sformatf("row%0d v_total_sat", i), int'(a_v_tot), 15);
                chk($sformatf("row%0d v_active_gap", i), int'(a_v_act), 8);
            end
            last_start = st;
        end

        chk("never_ok_and_err", both_seen, 0);
        chk("sync_pol0_equivalence", pol_mis, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
